backend_cycle_sequencer: RTL

BACKEND_CYCLE_SEQUENCER -- requirements
Module: backend_cycle_sequencer

---
 rtl/backend_sequencer_pkg.sv | 39 +++
 rtl/scan_address_counter.sv | 54 +++++
 rtl/backend_cycle_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/backend_sequencer_pkg.sv
// Shared definitions for the backend cycle sequencer: config register map,
// control bit positions, FSM state encoding and a half-word merge helper.
package backend_sequencer_pkg;

  localparam int unsigned CFG_ADDR_W = 6;
  localparam int unsigned CFG_DATA_W = 16;

  // Config register map
  localparam logic [CFG_ADDR_W-1:0] ADDR_CCR0_LO    = 6'h00;
  localparam logic [CFG_ADDR_W-1:0] ADDR_CCR0_HI    = 6'h01;
  localparam logic [CFG_ADDR_W-1:0] ADDR_CCR1_LO    = 6'h02;
  localparam logic [CFG_ADDR_W-1:0] ADDR_CCR1_HI    = 6'h03;
  localparam logic [CFG_ADDR_W-1:0] ADDR_FRAME_LO   = 6'h04;
  localparam logic [CFG_ADDR_W-1:0] ADDR_FRAME_HI   = 6'h05;
  localparam logic [CFG_ADDR_W-1:0] ADDR_ROW_LIMIT  = 6'h06;
  localparam logic [CFG_ADDR_W-1:0] ADDR_COL_LIMIT  = 6'h07;
  localparam logic [CFG_ADDR_W-1:0] ADDR_INVERTER   = 6'h08;
  localparam logic [CFG_ADDR_W-1:0] ADDR_DEAD_TIME  = 6'h09;
  localparam logic [CFG_ADDR_W-1:0] ADDR_CONTROL    = 6'h0A;

  // Control register bit positions
  localparam int unsigned CTRL_CONTINUOUS_BIT = 0;
  localparam int unsigned CTRL_COL_MAJOR_BIT  = 1;
  localparam int unsigned CTRL_W              = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Replace the lower or upper 16 bits of a 32-bit value with new data.
  function automatic logic [31:0] merge_half(input logic [31:0] cur,
                                             input logic [15:0] data,
                                             input logic        upper);
    return upper ? {data, cur[15:0]} : {cur[31:16], data};
  endfunction

endpackage

// File: rtl/scan_address_counter.sv
// Row/column scan address generator.
// Ports: clock, reset (sync, active-high), clear (zero the address),
//        advance (step one address), col_major (column-major order),
//        row_limit/col_limit (inclusive last index), row/col (current
//        address), wrap (current address is the last of the frame).
module scan_address_counter
  import backend_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic              col_major,
  input  logic [ADDR_W-1:0] row_limit,
  input  logic [ADDR_W-1:0] col_limit,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              wrap
);

  logic row_end_c;
  logic col_end_c;

  assign row_end_c = (row == row_limit);
  assign col_end_c = (col == col_limit);
  assign wrap      = row_end_c && col_end_c;

  // Fast index steps every advance; slow index steps when the fast one wraps.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (!col_major) begin
        if (col_end_c) begin
          col <= '0;
          row <= row_end_c ? '0 : row + ADDR_W'(1);
        end else begin
          col <= col + ADDR_W'(1);
        end
      end else begin
        if (row_end_c) begin
          row <= '0;
          col <= col_end_c ? '0 : col + ADDR_W'(1);
        end else begin
          row <= row + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/backend_cycle_sequencer.sv
// Backend cycle sequencer: a configurable period timer that walks a row/col
// address scan, generates a per-step drive window and counts frames.
// Ports: clock, reset (sync, active-high), timer_enable (run request),
//        write_config_n/config_address/config_data (register writes),
//        row_select/col_select (scan address), output_active (drive window),
//        inverter_select (config pass-through), step_advance (address step
//        pulse), update_cycle_complete (in DONE), busy (in RUN).
module backend_cycle_sequencer
  import backend_sequencer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH        = 32,
  parameter int unsigned MEM_ADDRESS_LENGTH = 7,
  parameter int unsigned INV_WIDTH          = 16,
  parameter int unsigned FRAME_WIDTH        = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          timer_enable,
  input  logic                          write_config_n,
  input  logic [CFG_ADDR_W-1:0]         config_address,
  input  logic [CFG_DATA_W-1:0]         config_data,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
  output logic                          output_active,
  output logic [INV_WIDTH-1:0]          inverter_select,
  output logic                          step_advance,
  output logic                          update_cycle_complete,
  output logic                          busy
);

  logic [TIMER_WIDTH-1:0]        ccr0_q;
  logic [TIMER_WIDTH-1:0]        ccr1_q;
  logic [TIMER_WIDTH-1:0]        dead_time_q;
  logic [FRAME_WIDTH-1:0]        frame_limit_q;
  logic [MEM_ADDRESS_LENGTH-1:0] row_limit_q;
  logic [MEM_ADDRESS_LENGTH-1:0] col_limit_q;
  logic [CTRL_W-1:0]             control_q;

  logic [TIMER_WIDTH-1:0]        timer_q;
  logic [FRAME_WIDTH-1:0]        frame_q;
  seq_state_e                    state_q;
  seq_state_e                    state_d;

  logic                          continuous_c;
  logic                          col_major_c;
  logic                          running_c;
  logic                          step_c;
  logic                          scan_wrap_c;
  logic [FRAME_WIDTH-1:0]        frame_next_c;
  logic                          frame_hit_c;
  logic                          frame_done_c;
  logic                          finish_c;
  logic                          scan_clear_c;

  // Config register file; one write per cycle, unknown addresses ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      ccr0_q          <= '0;
      ccr1_q          <= '0;
      dead_time_q     <= '0;
      frame_limit_q   <= '0;
      row_limit_q     <= '0;
      col_limit_q     <= '0;
      control_q       <= '0;
      inverter_select <= '0;
    end else if (!write_config_n) begin
      case (config_address)
        ADDR_CCR0_LO:   ccr0_q <= TIMER_WIDTH'(merge_half(32'(ccr0_q), config_data, 1'b0));
        ADDR_CCR0_HI:   ccr0_q <= TIMER_WIDTH'(merge_half(32'(ccr0_q), config_data, 1'b1));
        ADDR_CCR1_LO:   ccr1_q <= TIMER_WIDTH'(merge_half(32'(ccr1_q), config_data, 1'b0));
        ADDR_CCR1_HI:   ccr1_q <= TIMER_WIDTH'(merge_half(32'(ccr1_q), config_data, 1'b1));
        ADDR_FRAME_LO:  frame_limit_q <= FRAME_WIDTH'(merge_half(32'(frame_limit_q), config_data, 1'b0));
        ADDR_FRAME_HI:  frame_limit_q <= FRAME_WIDTH'(merge_half(32'(frame_limit_q), config_data, 1'b1));
        ADDR_ROW_LIMIT: row_limit_q <= MEM_ADDRESS_LENGTH'(config_data);
        ADDR_COL_LIMIT: col_limit_q <= MEM_ADDRESS_LENGTH'(config_data);
        ADDR_INVERTER:  inverter_select <= INV_WIDTH'(config_data);
        ADDR_DEAD_TIME: dead_time_q <= TIMER_WIDTH'(config_data);
        ADDR_CONTROL:   control_q <= config_data[CTRL_W-1:0];
        default: ;
      endcase
    end
  end

  assign continuous_c = control_q[CTRL_CONTINUOUS_BIT];
  assign col_major_c  = control_q[CTRL_COL_MAJOR_BIT];

  // A step only fires while the run request is still present, so dropping
  // timer_enable never produces a trailing address step.
  assign running_c    = (state_q == ST_RUN) && timer_enable;
  assign step_c       = running_c && (timer_q == ccr1_q);
  assign frame_next_c = frame_q + FRAME_WIDTH'(1);
  assign frame_hit_c  = (frame_limit_q != '0) && (frame_next_c == frame_limit_q);
  assign frame_done_c = step_c && scan_wrap_c && frame_hit_c;
  assign finish_c     = frame_done_c && !continuous_c;
  assign scan_clear_c = !timer_enable || (state_q == ST_IDLE);

  // Period timer: counts 0..ccr1 in RUN, held at zero otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else if (!running_c || step_c) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TIMER_WIDTH'(1);
    end
  end

  // Frame counter: bumps on each full scan, clears at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_q <= '0;
    end else if (!running_c) begin
      frame_q <= '0;
    end else if (step_c && scan_wrap_c) begin
      frame_q <= frame_hit_c ? '0 : frame_next_c;
    end
  end

  // The completing step of a one-shot run keeps the final address in view.
  scan_address_counter #(
    .ADDR_W(MEM_ADDRESS_LENGTH)
  ) u_scan (
    .clock     (clock),
    .reset     (reset),
    .clear     (scan_clear_c),
    .advance   (step_c && !finish_c),
    .col_major (col_major_c),
    .row_limit (row_limit_q),
    .col_limit (col_limit_q),
    .row       (row_select),
    .col       (col_select),
    .wrap      (scan_wrap_c)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (timer_enable) state_d = ST_RUN;
      ST_RUN: begin
        if (!timer_enable) begin
          state_d = ST_IDLE;
        end else if (finish_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (!timer_enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state and timer
  always_comb begin
    busy                  = 1'b0;
    update_cycle_complete = 1'b0;
    output_active         = 1'b0;
    step_advance          = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        busy          = 1'b1;
        step_advance  = step_c;
        output_active = (timer_q > dead_time_q) && (timer_q <= ccr0_q);
      end
      ST_DONE: update_cycle_complete = 1'b1;
      default: ;
    endcase
  end

endmodule
